// File: rtl/accu_pkg.sv
// rtl/accu_pkg.sv - op encodings shared by the multi-channel accumulator
package accu_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

endpackage

// File: rtl/accu_alu.sv
// rtl/accu_alu.sv - combinational add/sub/load/clear with wrap or clamp
module accu_alu
    import accu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] x,
    input  op_e          op,
    output logic [W-1:0] r,
    output logic         ovf_evt
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, x};
        diff    = {1'b0, a} - {1'b0, x};
        r       = '0;
        ovf_evt = 1'b0;
        unique case (op)
            OP_ADD: begin
                ovf_evt = sum[W];
                r       = ((SAT != 0) && sum[W]) ? '1 : sum[W-1:0];
            end
            OP_SUB: begin
                // the extra bit of the difference is the borrow
                ovf_evt = diff[W];
                r       = ((SAT != 0) && diff[W]) ? '0 : diff[W-1:0];
            end
            OP_LOAD: r = x;
            OP_CLR:  r = '0;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/accu_multi.sv
// rtl/accu_multi.sv - NCH unsigned accumulators on one datapath with a one-entry output register
module accu_multi
    import accu_pkg::*;
#(
    parameter int W    = 8,
    parameter int IN_W = 8,
    parameter int NCH  = 4,
    parameter int SAT  = 0,
    parameter int CW   = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   in_chan,
    input  logic [OP_W-1:0] in_op,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_chan,
    output logic [W-1:0]    out_data,
    output logic [NCH-1:0]  ovf,
    input  logic            ovf_clr
);

    logic [W-1:0]   acc_q [NCH];
    logic [W-1:0]   acc_d [NCH];
    logic           out_valid_q, out_valid_d;
    logic [CW-1:0]  out_chan_q, out_chan_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [NCH-1:0] ovf_q, ovf_d;

    logic           accept;
    logic           chan_ok;
    logic [W-1:0]   acc_sel;
    logic [W-1:0]   alu_r;
    logic           alu_ovf;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign chan_ok  = 32'(in_chan) < NCH;

    // selection by compare keeps out-of-range channel codes from indexing the array
    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (32'(in_chan) == i) acc_sel = acc_q[i];
        end
    end

    accu_alu #(
        .W   (W),
        .SAT (SAT)
    ) u_alu (
        .a       (acc_sel),
        .x       (W'(in_data)),
        .op      (op_e'(in_op)),
        .r       (alu_r),
        .ovf_evt (alu_ovf)
    );

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_clr ? '0 : ovf_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_chan_d  = in_chan;
            out_data_d  = chan_ok ? alu_r : '0;
            for (int i = 0; i < NCH; i++) begin
                if (chan_ok && (32'(in_chan) == i)) begin
                    acc_d[i] = alu_r;
                    // a fresh event outranks a same-cycle clear
                    if (alu_ovf) ovf_d[i] = 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            ovf_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_accu_multi.sv
// tb/tb_accu_multi.sv - randomized and directed bench for accu_multi against an arithmetic model
module tb_accu_multi;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_chan = '0;
    logic [1:0] in_op = '0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;
    logic       ovf_clr = 1'b0;

    logic       o_ready [NI];
    logic       o_valid [NI];
    logic [1:0] o_chan  [NI];
    logic [7:0] o_data  [NI];
    logic [3:0] ovf_a, ovf_b;
    logic [2:0] ovf_c;

    int checks = 0;
    int failures = 0;

    // instance 0: 4 ch wrap, 1: 4 ch clamp, 2: 3 ch wrap (channel 3 out of range)
    int nch  [NI] = '{4, 4, 3};
    int satv [NI] = '{0, 1, 0};

    always #5 clk = ~clk;

    accu_multi #(.W(8), .IN_W(8), .NCH(4), .SAT(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_chan(in_chan), .in_op(in_op), .in_data(in_data),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_chan(o_chan[0]),
        .out_data(o_data[0]), .ovf(ovf_a), .ovf_clr(ovf_clr));

    accu_multi #(.W(8), .IN_W(8), .NCH(4), .SAT(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_chan(in_chan), .in_op(in_op), .in_data(in_data),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_chan(o_chan[1]),
        .out_data(o_data[1]), .ovf(ovf_b), .ovf_clr(ovf_clr));

    accu_multi #(.W(8), .IN_W(8), .NCH(3), .SAT(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[2]),
        .in_chan(in_chan), .in_op(in_op), .in_data(in_data),
        .out_valid(o_valid[2]), .out_ready(out_ready), .out_chan(o_chan[2]),
        .out_data(o_data[2]), .ovf(ovf_c), .ovf_clr(ovf_clr));

    function automatic logic [3:0] dut_ovf(input int k);
        case (k)
            0:       return ovf_a;
            1:       return ovf_b;
            default: return {1'b0, ovf_c};
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: plain integer arithmetic per instance
    int         macc  [NI][4];
    logic [3:0] movf  [NI];
    int         mdata [NI];
    logic       mvalid = 1'b0;
    logic [1:0] mchan = '0;

    always @(posedge clk or negedge rst) begin : model
        bit take;
        int a, x, v, ch;
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < 4; c++) macc[k][c] = 0;
                movf[k]  = '0;
                mdata[k] = 0;
            end
            mvalid = 1'b0;
            mchan  = '0;
        end else begin
            take = in_valid && (!mvalid || out_ready);
            ch   = int'(in_chan);
            for (int k = 0; k < NI; k++) begin
                if (ovf_clr) movf[k] = '0;
                if (take) begin
                    if (ch < nch[k]) begin
                        a = macc[k][ch];
                        x = int'(in_data);
                        case (in_op)
                            2'd0: begin
                                v = a + x;
                                if (v > 255) begin
                                    movf[k][ch] = 1'b1;
                                    v = (satv[k] != 0) ? 255 : v - 256;
                                end
                            end
                            2'd1: begin
                                v = a - x;
                                if (v < 0) begin
                                    movf[k][ch] = 1'b1;
                                    v = (satv[k] != 0) ? 0 : v + 256;
                                end
                            end
                            2'd2: v = x;
                            default: v = 0;
                        endcase
                        macc[k][ch] = v;
                        mdata[k]    = v;
                    end else begin
                        mdata[k] = 0;
                    end
                end
            end
            if (take) begin
                mvalid = 1'b1;
                mchan  = in_chan;
            end else if (out_ready) begin
                mvalid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("m_valid[%0d]", k), int'(o_valid[k]), int'(mvalid));
                chk($sformatf("m_ready[%0d]", k), int'(o_ready[k]), int'(!mvalid || out_ready));
                chk($sformatf("m_ovf[%0d]", k), int'(dut_ovf(k)), int'(movf[k]));
                if (mvalid) begin
                    chk($sformatf("m_data[%0d]", k), int'(o_data[k]), mdata[k]);
                    chk($sformatf("m_chan[%0d]", k), int'(o_chan[k]), int'(mchan));
                end
            end
        end
    end

    task automatic op(input logic [1:0] o, input logic [1:0] c, input logic [7:0] d, input logic clr);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = o;
        in_chan  = c;
        in_data  = d;
        ovf_clr  = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", int'(o_valid[0]), 0);
        chk("rst_data", int'(o_data[0]), 0);
        chk("rst_ovf", int'(ovf_a), 0);
        chk("rst_ready", int'(o_ready[0]), 1);
        @(negedge clk);
        rst = 1'b1;

        // streaming adds on channel 0
        for (int i = 1; i <= 5; i++) begin
            op(2'd0, 2'd0, 8'd1, 1'b0);
            chk($sformatf("t1_data%0d", i), int'(o_data[0]), i);
            chk($sformatf("t1_chan%0d", i), int'(o_chan[0]), 0);
        end

        // wrap vs clamp on channels 1 and 2
        op(2'd2, 2'd1, 8'd250, 1'b0);
        op(2'd0, 2'd1, 8'd10, 1'b0);
        chk("t2_wrap_add", int'(o_data[0]), 4);
        chk("t2_sat_add", int'(o_data[1]), 255);
        chk("t2_ovf1", int'(ovf_a), 4'b0010);
        op(2'd1, 2'd2, 8'd1, 1'b0);
        chk("t2_wrap_sub", int'(o_data[0]), 255);
        chk("t2_ovf2", int'(ovf_a), 4'b0110);

        // clamp sequence on channel 3; out-of-range for the 3-channel instance
        op(2'd2, 2'd3, 8'd250, 1'b0);
        op(2'd0, 2'd3, 8'd10, 1'b0);
        chk("t3_sat_add", int'(o_data[1]), 255);
        chk("t3_ovf3", int'(ovf_b[3]), 1);
        chk("t3_bad_chan_data", int'(o_data[2]), 0);
        chk("t3_bad_chan_chan", int'(o_chan[2]), 3);
        chk("t3_bad_chan_ovf", int'(ovf_c), 3'b110);
        op(2'd2, 2'd3, 8'd3, 1'b0);
        op(2'd1, 2'd3, 8'd5, 1'b0);
        chk("t3_sat_sub", int'(o_data[1]), 0);
        op(2'd3, 2'd3, 8'd77, 1'b0);
        chk("t3_clr", int'(o_data[1]), 0);
        chk("t5_pre_ovf", int'(ovf_a), 4'b1110);

        // clear in the same cycle as a channel-0 overflow
        op(2'd2, 2'd0, 8'd255, 1'b0);
        op(2'd0, 2'd0, 8'd1, 1'b1);
        chk("t5_ovf", int'(ovf_a), 4'b0001);
        chk("t5_data", int'(o_data[0]), 0);
        idle();

        // backpressure with a held request
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'd0;
        in_chan   = 2'd0;
        in_data   = 8'd2;
        @(posedge clk);
        #2;
        chk("t4_first", int'(o_data[0]), 2);
        @(negedge clk);
        in_data = 8'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("t4_ready_low", int'(o_ready[0]), 0);
            chk("t4_hold_data", int'(o_data[0]), 2);
            chk("t4_hold_chan", int'(o_chan[0]), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("t4_release", int'(o_data[0]), 9);
        idle();

        // asynchronous reset between edges
        op(2'd0, 2'd1, 8'd3, 1'b0);
        op(2'd0, 2'd2, 8'd4, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_valid", int'(o_valid[0]), 0);
        chk("t6_data", int'(o_data[0]), 0);
        chk("t6_ovf", int'(ovf_a), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        op(2'd0, 2'd0, 8'd1, 1'b0);
        chk("t6_after", int'(o_data[0]), 1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            in_valid  = $urandom_range(0, 3) != 0;
            in_chan   = 2'($urandom_range(0, 3));
            in_op     = 2'($urandom_range(0, 3));
            in_data   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
            out_ready = $urandom_range(0, 3) != 0;
            ovf_clr   = $urandom_range(0, 15) == 0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
